// File: rtl/flag_pkg.sv
// Shared types for the flag/condition unit: branch kinds, ARM condition codes
// and the packed N/Z/V/C flag word.
package flag_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_B    = 2'b01,
        BR_COND = 2'b10,
        BR_CBZ  = 2'b11
    } br_type_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_HS = 4'h2,
        COND_LO = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    function automatic flags_t pack_flags(input logic n, input logic z,
                                          input logic v, input logic c);
        flags_t f;
        f.n = n;
        f.z = z;
        f.v = v;
        f.c = c;
        return f;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator; also used by decode-stage
// early branch resolution.
module cond_eval
    import flag_pkg::*;
(
    input  flags_t flags,
    input  cond_e  cond,
    output logic   taken
);

    logic ge;
    logic hi;

    assign ge = (flags.n == flags.v);
    assign hi = flags.c & ~flags.z;

    always_comb begin
        taken = 1'b1;
        unique case (cond)
            COND_EQ: taken = flags.z;
            COND_NE: taken = ~flags.z;
            COND_HS: taken = flags.c;
            COND_LO: taken = ~flags.c;
            COND_MI: taken = flags.n;
            COND_PL: taken = ~flags.n;
            COND_VS: taken = flags.v;
            COND_VC: taken = ~flags.v;
            COND_HI: taken = hi;
            COND_LS: taken = ~hi;
            COND_GE: taken = ge;
            COND_LT: taken = ~ge;
            COND_GT: taken = ~flags.z & ge;
            COND_LE: taken = ~(~flags.z & ge);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Stores N/Z/V/C on retiring flag-setting EX instructions and produces a
// registered branch verdict for B, B.cond and CBZ.
module flag_cond_unit
    import flag_pkg::*;
#(
    parameter int unsigned COND_W = 4,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic              ex_n,
    input  logic              ex_z,
    input  logic              ex_v,
    input  logic              ex_c,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic [COND_W-1:0] br_cond,
    input  logic              cbz_zero,
    output logic [3:0]        flags_q,
    output logic              br_done,
    output logic              br_taken
);

    flags_t   flags_r;
    flags_t   ex_flags;
    flags_t   eff_flags;
    br_type_e br_kind;
    cond_e    cond;
    logic     ex_update;
    logic     cond_taken;
    logic     br_req;
    logic     verdict;

    assign ex_flags  = pack_flags(ex_n, ex_z, ex_v, ex_c);
    assign ex_update = ex_valid & ex_set_flags & ~flush;
    assign br_kind   = br_type_e'(br_type);
    assign cond      = cond_e'(br_cond[3:0]);
    assign br_req    = br_valid & (br_kind != BR_NONE) & ~flush;

    // Forwarding lets a SUBS and the dependent B.cond resolve in the same cycle.
    assign eff_flags = (FWD_EN && ex_update) ? ex_flags : flags_r;

    cond_eval u_cond_eval (
        .flags (eff_flags),
        .cond  (cond),
        .taken (cond_taken)
    );

    always_comb begin
        verdict = 1'b0;
        unique case (br_kind)
            BR_B:    verdict = 1'b1;
            BR_COND: verdict = cond_taken;
            BR_CBZ:  verdict = cbz_zero;
            BR_NONE: verdict = 1'b0;
            default: verdict = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r  <= '0;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
        end else if (!stall) begin
            if (ex_update) begin
                flags_r <= ex_flags;
            end
            if (br_req) begin
                br_done  <= 1'b1;
                br_taken <= verdict;
            end else begin
                br_done  <= 1'b0;
            end
        end
    end

    assign flags_q = flags_r;

endmodule
